// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, state encoding and defaults for the binary-to-BCD converter
package bcd_pkg;
  localparam int WIDTH = 16;
  localparam int DIGITS = 5;
  localparam int BCD_DIGIT_W = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit corrector, adds 3 to any digit of 5 or more
import bcd_pkg::*;
module bcd_digit_adj (
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);
  // correction wraps within 4 bits; a valid digit never exceeds 9 so 12 is the maximum result
  always_comb q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-and-add-3 binary-to-BCD converter with valid/ready input and leading-zero blank mask
import bcd_pkg::*;
module bin2bcd_seq #(
  parameter int WIDTH = bcd_pkg::WIDTH,
  parameter int DIGITS = bcd_pkg::DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_blank
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   scr, adj, nxt_scr;
  logic [DIGITS-1:0]     mask;
  logic                  z;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(scr[4*i +: 4]), .q(adj[4*i +: 4]));
  end
  assign nxt_scr = {adj[4*DIGITS-2:0], bin[WIDTH-1]};
  assign in_ready = state == S_IDLE;
  // leading-zero mask of the post-shift scratch; digit 0 is never blanked so a zero result still shows "0"
  always_comb begin
    mask = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      z = z & (nxt_scr[4*i +: 4] == 4'd0);
      mask[i] = z;
    end
  end
  // handshake, shift sequencing and registered result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      bin <= '0;
      scr <= '0;
      out_valid <= 1'b0;
      out_bcd <= '0;
      out_blank <= BLANK_RST;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: if (in_valid) begin
          bin <= in_bin;
          scr <= '0;
          cnt <= CW'(WIDTH);
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          scr <= nxt_scr;
          bin <= {bin[WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            out_bcd <= nxt_scr;
            out_blank <= mask;
            out_valid <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_bin = '0;
  logic out_valid;
  logic [19:0] out_bcd;
  logic [4:0] out_blank;
  int checks = 0;
  int errors = 0;
  int lat, busy;

  bin2bcd_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bin(in_bin), .out_valid(out_valid), .out_bcd(out_bcd), .out_blank(out_blank)
  );

  always #5 clk = ~clk;

  // presents one word from idle and waits (bounded) for the result pulse
  task automatic run(input logic [15:0] v, output int l, output int b);
    @(negedge clk);
    in_valid = 1'b1;
    in_bin = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_bin = ~v;
    l = 0;
    b = 0;
    while (!out_valid && l < 40) begin
      if (!in_ready) b++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_during got %b want 1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_bcd !== 20'h00000) begin errors++; $display("FAIL rst_bcd got %h want 00000", out_bcd); end
    checks++; if (out_blank !== 5'b11110) begin errors++; $display("FAIL rst_blank got %b want 11110", out_blank); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready); end
  endtask

  task automatic test_zero;
    run(16'd0, lat, busy);
    checks++; if (lat !== 16) begin errors++; $display("FAIL zero_latency got %0d want 16", lat); end
    checks++; if (busy !== 16) begin errors++; $display("FAIL zero_busy got %0d want 16", busy); end
    checks++; if (out_bcd !== 20'h00000) begin errors++; $display("FAIL zero_bcd got %h want 00000", out_bcd); end
    checks++; if (out_blank !== 5'b11110) begin errors++; $display("FAIL zero_blank got %b want 11110", out_blank); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_at_valid got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_pulse_width got %b want 0", out_valid); end
  endtask

  task automatic test_values;
    logic [15:0] vin [3] = '{16'hFFFF, 16'd13, 16'hB520};
    logic [19:0] vbcd [3] = '{20'h65535, 20'h00013, 20'h46368};
    logic [4:0] vblk [3] = '{5'b00000, 5'b11100, 5'b00000};
    for (int k = 0; k < 3; k++) begin
      run(vin[k], lat, busy);
      checks++; if (lat !== 16) begin errors++; $display("FAIL val%0d_latency got %0d want 16", k, lat); end
      checks++; if (out_bcd !== vbcd[k]) begin errors++; $display("FAIL val%0d_bcd got %h want %h", k, out_bcd, vbcd[k]); end
      checks++; if (out_blank !== vblk[k]) begin errors++; $display("FAIL val%0d_blank got %b want %b", k, out_blank, vblk[k]); end
      @(negedge clk);
      checks++; if (out_bcd !== vbcd[k]) begin errors++; $display("FAIL val%0d_hold got %h want %h", k, out_bcd, vbcd[k]); end
    end
  endtask

  task automatic test_back_to_back;
    int l2;
    int bad_hold;
    @(negedge clk);
    in_valid = 1'b1;
    in_bin = 16'd233;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_bin = lat < 14 ? (lat[0] ? 16'hFFFF : 16'd9999) : 16'd377;
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 16) begin errors++; $display("FAIL b2b_first_latency got %0d want 16", lat); end
    checks++; if (out_bcd !== 20'h00233) begin errors++; $display("FAIL b2b_first_bcd got %h want 00233", out_bcd); end
    checks++; if (out_blank !== 5'b11000) begin errors++; $display("FAIL b2b_first_blank got %b want 11000", out_blank); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    l2 = 0;
    bad_hold = 0;
    @(negedge clk);
    l2++;
    in_valid = 1'b0;
    in_bin = 16'd5555;
    while (!out_valid && l2 < 40) begin
      if (out_bcd !== 20'h00233) bad_hold++;
      @(negedge clk);
      l2++;
    end
    checks++; if (bad_hold !== 0) begin errors++; $display("FAIL b2b_hold got %0d changes want 0", bad_hold); end
    checks++; if (l2 !== 17) begin errors++; $display("FAIL b2b_second_latency got %0d want 17", l2); end
    checks++; if (out_bcd !== 20'h00377) begin errors++; $display("FAIL b2b_second_bcd got %h want 00377", out_bcd); end
    checks++; if (out_blank !== 5'b11000) begin errors++; $display("FAIL b2b_second_blank got %b want 11000", out_blank); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    @(negedge clk);
    in_valid = 1'b1;
    in_bin = 16'd1000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_bcd !== 20'h00000) begin errors++; $display("FAIL mid_rst_bcd got %h want 00000", out_bcd); end
    checks++; if (out_blank !== 5'b11110) begin errors++; $display("FAIL mid_rst_blank got %b want 11110", out_blank); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_no_pulse got %0d want 0", pulses); end
    run(16'd1000, lat, busy);
    checks++; if (lat !== 16) begin errors++; $display("FAIL mid_after_latency got %0d want 16", lat); end
    checks++; if (out_bcd !== 20'h01000) begin errors++; $display("FAIL mid_after_bcd got %h want 01000", out_bcd); end
    checks++; if (out_blank !== 5'b10000) begin errors++; $display("FAIL mid_after_blank got %b want 10000", out_blank); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_values;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
